// File: rtl/lcd_write_sequencer_pkg.sv
// Shared definitions for the LCD write sequencer: FSM states, the power-on
// instruction table and the opcodes that need the long settle time.
package lcd_write_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_STROBE  = 3'd4,
        ST_HOLD    = 3'd5,
        ST_WAIT    = 3'd6
    } lcd_state_e;

    // Function set (8-bit, 2 lines), display on, clear, entry mode; entry 0 in the low byte.
    localparam int         INIT_LEN   = 4;
    localparam logic [1:0] INIT_LAST  = 2'd3;
    localparam logic [31:0] INIT_TABLE = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    function automatic logic [7:0] init_instr(input logic [1:0] idx);
        return INIT_TABLE[{idx, 3'b000} +: 8];
    endfunction

    // Clear and return-home instructions need the long settle time; data bytes never do.
    function automatic logic needs_long_settle(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == OP_CLEAR) || (data == OP_HOME));
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding queued LCD commands; full/empty derived from an occupancy count.
module lcd_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int           AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    // Storage array: written on push, no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// Drives an HD44780-style LCD through a bus slave: power-up delay, fixed init
// sequence, then queued commands, each as SETUP / STROBE / HOLD / WAIT.
module lcd_write_sequencer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int E_CYCLES       = 12,
    parameter int WAIT_CYCLES    = 2500,
    parameter int CLEAR_CYCLES   = 82000,
    parameter int POWERUP_CYCLES = 750000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic [1:0] lcd_address,
    output logic       lcd_write,
    output logic       lcd_read,
    output logic [7:0] lcd_writedata,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_A      = (E_CYCLES > WAIT_CYCLES) ? E_CYCLES : WAIT_CYCLES;
    localparam int MAX_B      = (CLEAR_CYCLES > POWERUP_CYCLES) ? CLEAR_CYCLES : POWERUP_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    // The counter is loaded with N-1 so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_E       = CNT_W'(E_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WAIT    = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    lcd_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       step_r, step_s;
    logic             init_done_r, init_done_s;
    logic             rs_r, rs_s;
    logic [7:0]       data_r, data_s;
    logic             lcd_write_r;
    logic             cnt_zero_s;
    logic             fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [8:0]       fifo_rd_s;

    assign fifo_push_s = cmd_valid && !fifo_full_s;

    lcd_cmd_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push_s),
        .wr_data ({cmd_rs, cmd_data}),
        .pop     (fifo_pop_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign cnt_zero_s = (cnt_r == '0);

    // Next-state, counter reload and command latch; back-to-back commands skip IDLE.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        step_s      = step_r;
        init_done_s = init_done_r;
        rs_s        = rs_r;
        data_s      = data_r;
        fifo_pop_s  = 1'b0;
        case (state_r)
            ST_POWERUP: begin
                if (cnt_zero_s) begin
                    state_s = ST_INIT;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_INIT: begin
                rs_s    = 1'b0;
                data_s  = init_instr(step_r);
                state_s = ST_SETUP;
            end
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s       = 1'b1;
                    {rs_s, data_s}   = fifo_rd_s;
                    state_s          = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
                cnt_s   = LD_E;
            end
            ST_STROBE: begin
                if (cnt_zero_s) begin
                    state_s = ST_HOLD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                state_s = ST_WAIT;
                cnt_s   = needs_long_settle(rs_r, data_r) ? LD_CLEAR : LD_WAIT;
            end
            ST_WAIT: begin
                if (!cnt_zero_s) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (!init_done_r) begin
                    if (step_r == INIT_LAST) begin
                        init_done_s = 1'b1;
                        state_s     = ST_IDLE;
                    end else begin
                        step_s  = step_r + 2'd1;
                        state_s = ST_INIT;
                    end
                end else if (!fifo_empty_s) begin
                    fifo_pop_s     = 1'b1;
                    {rs_s, data_s} = fifo_rd_s;
                    state_s        = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_POWERUP;
                cnt_s   = LD_POWERUP;
            end
        endcase
    end

    // State, counter and registered LCD outputs; lcd_write follows entry into STROBE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_POWERUP;
            cnt_r       <= LD_POWERUP;
            step_r      <= 2'd0;
            init_done_r <= 1'b0;
            rs_r        <= 1'b0;
            data_r      <= 8'h00;
            lcd_write_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            step_r      <= step_s;
            init_done_r <= init_done_s;
            rs_r        <= rs_s;
            data_r      <= data_s;
            lcd_write_r <= (state_s == ST_STROBE);
        end
    end

    assign cmd_ready     = !fifo_full_s;
    assign lcd_address   = {rs_r, 1'b0};
    assign lcd_writedata = data_r;
    assign lcd_write     = lcd_write_r;
    assign lcd_read      = 1'b0;
    assign init_done     = init_done_r;
    assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed and randomized bench for lcd_write_sequencer with a timing/order model
// derived from the write protocol (power-up delay, init table, settle rules).
module tb_lcd_write_sequencer;

    localparam int E_C   = 3;
    localparam int W_C   = 5;
    localparam int CLR_C = 20;
    localparam int PU_C  = 10;
    localparam int DEPTH = 16;
    localparam int LIMIT = 1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid, cmd_ready, cmd_rs;
    logic [7:0] cmd_data;
    logic [1:0] lcd_address;
    logic       lcd_write, lcd_read;
    logic [7:0] lcd_writedata;
    logic       init_done, busy;

    int cyc;
    int last_fall;
    int last_rise;
    int n_tests;
    int n_fail;

    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_write_sequencer #(
        .E_CYCLES       (E_C),
        .WAIT_CYCLES    (W_C),
        .CLEAR_CYCLES   (CLR_C),
        .POWERUP_CYCLES (PU_C),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rs        (cmd_rs),
        .cmd_data      (cmd_data),
        .lcd_address   (lcd_address),
        .lcd_write     (lcd_write),
        .lcd_read      (lcd_read),
        .lcd_writedata (lcd_writedata),
        .init_done     (init_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Rising-edge count since reset release.
    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic int settle(input logic [8:0] c);
        return (!c[8] && (c[7:0] == 8'h01 || c[7:0] == 8'h02)) ? CLR_C : W_C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d, output bit ok, output int acc);
        cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
        ok = 1'b0; acc = 0;
        for (int t = 0; t < LIMIT && !ok; t++) begin
            if (cmd_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            if (ok) acc = cyc;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic observe(input logic rs, input logic [7:0] d, input int exp_gap, input string tag);
        int t, width;
        logic [1:0] a0;
        logic [7:0] d0;
        bit stable;
        t = 0;
        while (lcd_write !== 1'b1 && t < LIMIT) begin
            @(negedge clk); t++;
        end
        check({tag, " strobe seen"}, 32'(t < LIMIT), 32'd1);
        if (t >= LIMIT) return;
        last_rise = cyc;
        if (exp_gap >= 0) check({tag, " gap"}, cyc - last_fall, exp_gap);
        check({tag, " address"}, lcd_address, {rs, 1'b0});
        check({tag, " data"}, lcd_writedata, d);
        a0 = lcd_address; d0 = lcd_writedata; stable = 1'b1; width = 0;
        while (lcd_write === 1'b1 && width < LIMIT) begin
            if (lcd_address !== a0 || lcd_writedata !== d0 || lcd_read !== 1'b0 || lcd_address[0] !== 1'b0)
                stable = 1'b0;
            width++;
            @(negedge clk);
        end
        check({tag, " strobe width"}, width, E_C);
        check({tag, " stable"}, 32'(stable), 32'd1);
        last_fall = cyc;
    endtask

    task automatic wait_idle(input int w, input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            @(negedge clk); n++;
        end
        check({tag, " busy low after strobe"}, n, w + 1);
    endtask

    task automatic observe_init(input string tag);
        int gap;
        gap = PU_C + 2;
        for (int i = 0; i < 4; i++) begin
            observe(1'b0, init_seq[i], gap, $sformatf("%s init%0d", tag, i));
            check($sformatf("%s init_done low at step %0d", tag, i), init_done, 1'b0);
            gap = settle({1'b0, init_seq[i]}) + 3;
        end
    endtask

    initial begin
        logic [8:0] cmds [17];
        logic [8:0] singles [8];
        bit ok, all_imm;
        int acc, acc17, first_rise, t, rises;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
        n_tests = 0; n_fail = 0; last_fall = 0; last_rise = 0;
        repeat (3) @(negedge clk);
        check("reset lcd_write", lcd_write, 1'b0);
        check("reset address", lcd_address, 2'b00);
        check("reset writedata", lcd_writedata, 8'h00);
        check("reset init_done", init_done, 1'b0);
        check("reset cmd_ready", cmd_ready, 1'b1);
        check("reset busy", busy, 1'b1);
        check("reset lcd_read", lcd_read, 1'b0);

        for (int i = 0; i < 17; i++) cmds[i] = {1'($urandom_range(0, 1)), 8'($urandom)};

        reset_n = 1'b1; last_fall = 0;
        acc17 = 0; first_rise = 0;
        fork
            begin : producer
                all_imm = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    push(cmds[i][8], cmds[i][7:0], ok, acc);
                    if (!ok || acc != i + 1) all_imm = 1'b0;
                end
                check("burst of 16 accepted back-to-back", 32'(all_imm), 32'd1);
                check("cmd_ready low when full", cmd_ready, 1'b0);
                push(cmds[16][8], cmds[16][7:0], ok, acc17);
                check("17th accepted", 32'(ok), 32'd1);
            end
            begin : consumer
                observe_init("boot");
                for (int i = 0; i < 16; i++) begin
                    observe(cmds[i][8], cmds[i][7:0],
                            (i == 0) ? settle({1'b0, init_seq[3]}) + 3 : settle(cmds[i-1]) + 2,
                            $sformatf("burst%0d", i));
                    if (i == 0) begin
                        first_rise = last_rise;
                        check("init_done high after init", init_done, 1'b1);
                    end
                end
            end
        join
        check("17th accepted the edge after first pop", acc17, first_rise);
        observe(cmds[16][8], cmds[16][7:0], settle(cmds[15]) + 2, "burst16");
        wait_idle(settle(cmds[16]), "burst16");

        singles[0] = {1'b1, 8'h41};
        singles[1] = {1'b0, 8'h02};
        singles[2] = {1'b1, 8'h02};
        singles[3] = {1'b0, 8'h01};
        for (int i = 4; i < 8; i++) singles[i] = {1'($urandom_range(0, 1)), 8'($urandom)};
        for (int i = 0; i < 8; i++) begin
            push(singles[i][8], singles[i][7:0], ok, acc);
            observe(singles[i][8], singles[i][7:0], -1, $sformatf("single%0d", i));
            wait_idle(settle(singles[i]), $sformatf("single%0d", i));
        end
        check("init_done stays high", init_done, 1'b1);

        // Reset in the middle of a strobe with another command still queued.
        push(1'b1, 8'h55, ok, acc);
        push(1'b1, 8'hAA, ok, acc);
        t = 0;
        while (lcd_write !== 1'b1 && t < LIMIT) begin
            @(negedge clk); t++;
        end
        check("strobe before reset", 32'(t < LIMIT), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid-strobe reset lcd_write", lcd_write, 1'b0);
        check("mid-strobe reset address", lcd_address, 2'b00);
        check("mid-strobe reset data", lcd_writedata, 8'h00);
        check("mid-strobe reset init_done", init_done, 1'b0);
        check("mid-strobe reset cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; last_fall = 0;
        observe_init("rerun");
        wait_idle(W_C, "rerun init");
        check("init_done after rerun", init_done, 1'b1);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_write === 1'b1) rises++;
        end
        check("queue discarded by reset", rises, 0);
        check("busy low with empty queue", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
